// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and sequencer state encoding for the colour-transform
// ALU front end.
//   PIX_W       - packed 8:8:8 RGB pixel width fed to the ALU
//   RES_W       - packed {p1,p2,p3} 3x16b ALU result width
//   seq_state_e - frame sequencer states
package alu_pkg;

  localparam int PIX_W = 24;
  localparam int RES_W = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_result_fifo.sv
// seq_result_fifo: small synchronous FIFO holding ALU results until the
// downstream stream accepts them. The caller guarantees no push when full
// (credit scheme) and no pop when empty (pop is gated by valid).
//   clk, rst_n - clock, asynchronous active-low clear (FIFO becomes empty)
//   push, din  - write strobe and data
//   pop, dout  - read strobe and head-of-queue data (show-ahead)
//   count      - current number of stored entries
module seq_result_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_pixel_sequencer.sv
// alu_pixel_sequencer: frame-level controller for the 3x3 colour-transform ALU.
// Reads one frame in raster order from the frame buffer, streams each pixel
// through the (enable-less, fixed-latency) ALU, tags in-flight pixels so their
// results can be caught, and buffers results in a credit-protected FIFO that
// drives a valid/ready output stream.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start/busy/done   - frame start pulse, frame active, end-of-frame pulse
//   rd_en/rd_addr     - frame-buffer read strobe and linear address
//   rd_data, alu_pix  - frame-buffer pixel, passed straight to the ALU
//   alu_out           - ALU result {p1,p2,p3}
//   m_valid/m_ready   - result stream handshake
//   m_data/m_last     - result beat and end-of-frame marker
module alu_pixel_sequencer
  import alu_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int ADDR_W     = 19,
  parameter int RAM_LAT    = 1,
  parameter int ALU_LAT    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  alu_pix,
  input  logic [RES_W-1:0]  alu_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [RES_W-1:0]  m_data,
  output logic              m_last
);

  localparam int N     = IMG_W * IMG_H;
  localparam int L     = RAM_LAT + ALU_LAT;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [L-1:0]      tag_v_q, tag_v_d;
  logic [L-1:0]      tag_l_q, tag_l_d;
  logic              done_q, done_d;
  logic              issue_s, push_s, pop_s;
  logic [CNT_W-1:0]  fifo_count_s, inflight_s, credits_s;
  logic [RES_W:0]    fifo_dout_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [L-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < L; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Credits come only from registered state, so m_ready never reaches rd_en
  // combinationally; a same-cycle pop is simply picked up one cycle later.
  assign inflight_s = popcount(tag_v_q);
  assign credits_s  = DEPTH_C - fifo_count_s - inflight_s;

  // Result exits the tag pipe exactly when the ALU output belongs to it.
  assign push_s = tag_v_q[L-1];
  assign pop_s  = m_valid && m_ready;

  // Frame sequencing, read issue and tag-pipe shift.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    last_addr_d = last_addr_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    tag_v_d     = {tag_v_q[L-2:0], 1'b0};
    tag_l_d     = {tag_l_q[L-2:0], 1'b0};
    case (state_q)
      IDLE: begin
        // The done cycle is already IDLE; a start there is deliberately dropped.
        if (start && !done_q) begin
          state_d   = RUN;
          pix_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (credits_s != '0) begin
          issue_s     = 1'b1;
          last_addr_d = pix_cnt_q;
          tag_v_d[0]  = 1'b1;
          tag_l_d[0]  = (pix_cnt_q == LAST_ADDR);
          if (pix_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      DRAIN: begin
        // The last-tagged beat is the final one pushed, so its handshake
        // implies the tag pipe and FIFO are both empty afterwards.
        if (pop_s && fifo_dout_s[RES_W]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset also clears every tag so stale ALU data is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      last_addr_q <= '0;
      tag_v_q     <= '0;
      tag_l_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      last_addr_q <= last_addr_d;
      tag_v_q     <= tag_v_d;
      tag_l_q     <= tag_l_d;
      done_q      <= done_d;
    end
  end

  seq_result_fifo #(
    .WIDTH (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   ({tag_l_q[L-1], alu_out}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s)
  );

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rd_en   = issue_s;
  // Address holds the last issued value between reads.
  assign rd_addr = issue_s ? pix_cnt_q : last_addr_q;
  assign alu_pix = rd_data;
  assign m_valid = (fifo_count_s != '0);
  assign m_data  = fifo_dout_s[RES_W-1:0];
  assign m_last  = m_valid && fifo_dout_s[RES_W];

endmodule
